breakout_session_ctrl: RTL
==========================

BREAKOUT_SESSION_CTRL -- requirements
Module: breakout_session_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 25_000_000: vga_clk cycles per one-second tick.
REQ-002 Parameter DEBOUNCE_CYC, default 250_000: cycles a synchronized button must stay stable before its debounced level changes.
REQ-003 Parameter COUNT_SEC, default 3, legal 1..9: countdown length in seconds.
REQ-004 Parameter RESULT_SEC, default 5, legal 1..15: seconds the win/lose screen is held.
REQ-005 vga_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 sys_rst  in  1  synchronous, active-high reset.
REQ-007 start_btn  in  1  raw asynchronous start/abort button, active-high.
REQ-008 pause_btn  in  1  raw asynchronous pause button, active-high.
REQ-009 game_win  in  1  win flag from the game core, level.
REQ-010 game_lose  in  1  lose flag from the game core, level.
REQ-011 game_active  out  1  enable to the game core.
REQ-012 run_en  out  1  clock-enable for the core's ball and paddle update logic; 0 freezes motion.
REQ-013 core_rst  out  1  active-high reset to the game core; integration inverts it to the core's active-low reset.
REQ-014 screen_sel  out  2  pixel-mux select: 0 game, 1 title, 2 win banner, 3 lose banner.
REQ-015 countdown  out  4  seconds remaining; 0 outside COUNTDOWN.
REQ-016 state  out  3  encoding: IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, RESULT=4.
REQ-017 win_count, lose_count  out  8 each  session totals, saturating at 255.

Function
REQ-018 Each button SHALL be synchronized through 2 flops, then debounced: the debounced level takes the synchronized value only after it differs from the current level for DEBOUNCE_CYC consecutive cycles; any mismatch gap restarts the count.
REQ-019 A debounced rising edge SHALL produce a 1-cycle start_p or pause_p pulse; holding a button SHALL NOT repeat the pulse.
REQ-020 A second counter SHALL run 0..CLK_HZ-1, emit tick on value CLK_HZ-1, wrap to 0, and clear to 0 on every state change.
REQ-021 IDLE SHALL drive game_active=0, run_en=0, core_rst=1, screen_sel=1; start_p moves to COUNTDOWN and loads countdown=COUNT_SEC.
REQ-022 COUNTDOWN SHALL drive game_active=0, run_en=0, core_rst=0, screen_sel=0; each tick decrements countdown; a tick while countdown==1 moves to PLAY with countdown=0; start_p aborts to IDLE.
REQ-023 PLAY SHALL drive game_active=1, run_en=1, screen_sel=0; game_win or game_lose moves to RESULT; otherwise pause_p moves to PAUSE, and otherwise start_p aborts to IDLE.
REQ-024 Win/lose SHALL take priority over pause_p and start_p in the same cycle; if game_win and game_lose are both 1, the cycle SHALL count as a win.
REQ-025 On PLAY->RESULT, result_win (internal) SHALL latch game_win, and the matching counter SHALL increment by exactly 1, saturating at 255.
REQ-026 PAUSE SHALL drive game_active=1, run_en=0, screen_sel=0; pause_p returns to PLAY; start_p aborts to IDLE; win/lose are ignored while paused.
REQ-027 RESULT SHALL drive game_active=1 and run_en=0, with screen_sel=2 if result_win, else 3.
REQ-028 RESULT SHALL count ticks and return to IDLE on the RESULT_SEC-th tick, or earlier on start_p.
REQ-029 The core SHALL be reset only through IDLE, so its latched win/lose flags clear before the next session.
REQ-030 Outputs SHALL be registered and valid 1 cycle after the state transition.

Reset
REQ-031 While sys_rst=1, the block SHALL hold state=IDLE, game_active=0, run_en=0, core_rst=1, screen_sel=1, countdown=0, win_count=0, lose_count=0, and clear all debounce, synchronizer and tick counters.
REQ-032 Reset asserted in any state, including mid-countdown or mid-debounce, SHALL take effect at the next edge with no pending pulse surviving.

Verification (CLK_HZ=20, DEBOUNCE_CYC=4, COUNT_SEC=3, RESULT_SEC=2)
REQ-033 Press start for 10 cycles -> exactly one start_p, state 1, countdown 3; countdown reaches 2, 1, 0 at successive ticks, and state=2 with game_active=1 and run_en=1 after 60 cycles.
REQ-034 In PLAY, 3-cycle start glitch -> no transition; then a pause press -> state 3, run_en=0, game_active=1; a second pause press -> state 2.
REQ-035 In PLAY, game_lose=1 together with a pause_p in the same cycle -> state 4, screen_sel=3, lose_count=1; after 40 cycles -> state 0 and core_rst=1.
REQ-036 game_win and game_lose both 1 in PLAY -> screen_sel=2, win_count +1, lose_count unchanged; 256 wins -> win_count stays 255.
REQ-037 sys_rst pulsed during COUNTDOWN with countdown=2 -> next cycle state=0, countdown=0, counts=0, no start_p follows while start_btn remains held.

Source files
------------

// File: rtl/breakout_session_ctrl.sv
// Breakout session sequencer: debounced start/pause buttons drive the
// title / countdown / play / pause / result flow and the game-core enables.
module breakout_session_ctrl #(
  parameter int CLK_HZ       = 25_000_000,
  parameter int DEBOUNCE_CYC = 250_000,
  parameter int COUNT_SEC    = 3,
  parameter int RESULT_SEC   = 5
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       game_win,
  input  logic       game_lose,
  output logic       game_active,
  output logic       run_en,
  output logic       core_rst,
  output logic [1:0] screen_sel,
  output logic [3:0] countdown,
  output logic [2:0] state,
  output logic [7:0] win_count,
  output logic [7:0] lose_count
);

  localparam int SW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CD    = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_RES   = 3'd4
  } state_e;

  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         lvl_q, lvl_d;
  logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]         pulse_q, pulse_d;
  state_e             state_q, state_d;
  logic [SW-1:0]      sec_q, sec_d;
  logic [3:0]         cd_q, cd_d;
  logic [3:0]         res_q, res_d;
  logic               res_win_q, res_win_d;
  logic [7:0]         win_q, win_d;
  logic [7:0]         lose_q, lose_d;
  logic               ga_q, ga_d;
  logic               run_q, run_d;
  logic               crst_q, crst_d;
  logic [1:0]         scr_q, scr_d;
  logic               start_p, pause_p, tick;

  assign start_p = pulse_q[0];
  assign pause_p = pulse_q[1];
  assign tick    = (sec_q == SW'(CLK_HZ - 1));

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl_d[i]    = lvl_q[i];
      db_cnt_d[i] = '0;
      pulse_d[i]  = 1'b0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
          lvl_d[i]   = sync2_q[i];
          pulse_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    res_d     = res_q;
    res_win_d = res_win_q;
    win_d     = win_q;
    lose_d    = lose_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_p) begin
          state_d = S_CD;
          cd_d    = 4'(COUNT_SEC);
        end
      end
      S_CD: begin
        if (start_p) begin
          state_d = S_IDLE;
          cd_d    = '0;
        end else if (tick) begin
          if (cd_q == 4'd1) begin
            state_d = S_PLAY;
            cd_d    = '0;
          end else begin
            cd_d = cd_q - 4'd1;
          end
        end
      end
      S_PLAY: begin
        if (game_win || game_lose) begin
          state_d   = S_RES;
          res_win_d = game_win;
          res_d     = '0;
          if (game_win) begin
            if (win_q != 8'hFF) win_d = win_q + 8'd1;
          end else begin
            if (lose_q != 8'hFF) lose_d = lose_q + 8'd1;
          end
        end else if (pause_p) begin
          state_d = S_PAUSE;
        end else if (start_p) begin
          state_d = S_IDLE;
        end
      end
      S_PAUSE: begin
        if (start_p) state_d = S_IDLE;
        else if (pause_p) state_d = S_PLAY;
      end
      S_RES: begin
        if (start_p) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (res_q == 4'(RESULT_SEC - 1)) state_d = S_IDLE;
          else res_d = res_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // second counter restarts whenever the state changes
  always_comb begin
    sec_d = (tick || state_d != state_q) ? '0 : sec_q + SW'(1);
    ga_d   = (state_d == S_PLAY) || (state_d == S_PAUSE) || (state_d == S_RES);
    run_d  = (state_d == S_PLAY);
    crst_d = (state_d == S_IDLE);
    scr_d  = 2'd0;
    if (state_d == S_IDLE) scr_d = 2'd1;
    else if (state_d == S_RES) scr_d = res_win_d ? 2'd2 : 2'd3;
  end

  // debounced level starts high so a button held through reset
  // must be seen released before it can pulse again
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= 2'b11;
      db_cnt_q  <= '0;
      pulse_q   <= '0;
      state_q   <= S_IDLE;
      sec_q     <= '0;
      cd_q      <= '0;
      res_q     <= '0;
      res_win_q <= 1'b0;
      win_q     <= '0;
      lose_q    <= '0;
      ga_q      <= 1'b0;
      run_q     <= 1'b0;
      crst_q    <= 1'b1;
      scr_q     <= 2'd1;
    end else begin
      sync1_q   <= {pause_btn, start_btn};
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      db_cnt_q  <= db_cnt_d;
      pulse_q   <= pulse_d;
      state_q   <= state_d;
      sec_q     <= sec_d;
      cd_q      <= cd_d;
      res_q     <= res_d;
      res_win_q <= res_win_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      ga_q      <= ga_d;
      run_q     <= run_d;
      crst_q    <= crst_d;
      scr_q     <= scr_d;
    end
  end

  assign state       = state_q;
  assign countdown   = cd_q;
  assign game_active = ga_q;
  assign run_en      = run_q;
  assign core_rst    = crst_q;
  assign screen_sel  = scr_q;
  assign win_count   = win_q;
  assign lose_count  = lose_q;

endmodule
